// File: rtl/lut_table_loader.sv
// lut_table_loader: runtime-loadable truth table for one neuron.
// A table is streamed in over s_data/s_valid/s_ready, stored in a small
// distributed RAM (one row per beat), and served with a registered
// one-cycle lookup once the whole table has been committed.
// Optional build macro LUT_CHECKSUM_EN: an extra beat carrying the XOR of
// all data beats is required before the table is committed.
module lut_table_loader #(
    parameter int IN_BITS      = 6,
    parameter int OUT_BITS     = 2,
    parameter int BEAT_ENTRIES = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load_start,
    input  logic [BEAT_ENTRIES*OUT_BITS-1:0] s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    output logic                             load_done,
    output logic                             table_valid,
    input  logic                             lkp_en,
    input  logic [IN_BITS-1:0]               lkp_addr,
    output logic [OUT_BITS-1:0]              lkp_data,
    output logic                             lkp_valid,
    output logic                             err
);

    localparam int BEAT_W    = BEAT_ENTRIES * OUT_BITS;
    localparam int NUM_BEATS = (2 ** IN_BITS) / BEAT_ENTRIES;
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int LANE_W    = $clog2(BEAT_ENTRIES);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   table_valid_q, table_valid_d;
    logic                   load_done_q, load_done_d;
    logic [OUT_BITS-1:0]    lkp_data_q, lkp_data_d;
    logic                   lkp_valid_q, lkp_valid_d;
    logic                   wr_en;
    logic [CNT_W-1:0]       rd_row;
    logic [IN_BITS-1:0]     rd_lane;
    logic [OUT_BITS-1:0]    rd_entry;

    logic [BEAT_W-1:0]      mem [NUM_BEATS];

`ifdef LUT_CHECKSUM_EN
    logic [BEAT_W-1:0]      csum_q, csum_d;
    logic                   err_q, err_d;
`endif

    // Row/lane decode and lane select of the addressed table entry.
    always_comb begin
        rd_row   = CNT_W'(lkp_addr >> LANE_W);
        rd_lane  = lkp_addr & IN_BITS'(BEAT_ENTRIES - 1);
        rd_entry = '0;
        for (int k = 0; k < BEAT_ENTRIES; k++) begin
            if (IN_BITS'(k) == rd_lane) begin
                rd_entry = mem[rd_row][k*OUT_BITS +: OUT_BITS];
            end
        end
    end

    // Next-state, beat accept, counter and commit logic of the load FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d       = state_q;
        cnt_d         = cnt_q;
        table_valid_d = table_valid_q;
        load_done_d   = 1'b0;
        wr_en         = 1'b0;
`ifdef LUT_CHECKSUM_EN
        csum_d        = csum_q;
        err_d         = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d       = LOAD;
                    cnt_d         = '0;
                    table_valid_d = 1'b0;
`ifdef LUT_CHECKSUM_EN
                    csum_d        = '0;
                    err_d         = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (load_start) begin
                    cnt_d = '0;
`ifdef LUT_CHECKSUM_EN
                    csum_d = '0;
`endif
                end else if (s_valid) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef LUT_CHECKSUM_EN
                    csum_d = csum_q ^ s_data;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = CHECK;
                    end
`else
                    if (cnt_q == LAST_BEAT) begin
                        state_d       = DONE;
                        load_done_d   = 1'b1;
                        table_valid_d = 1'b1;
                    end
`endif
                end
            end
`ifdef LUT_CHECKSUM_EN
            CHECK: begin
                if (load_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    csum_d  = '0;
                end else if (s_valid) begin
                    if (s_data == csum_q) begin
                        state_d       = DONE;
                        load_done_d   = 1'b1;
                        table_valid_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered lookup: gated by a committed table, zero otherwise.
    always_comb begin
        lkp_valid_d = lkp_en & table_valid_q;
        lkp_data_d  = lkp_valid_d ? rd_entry : '0;
    end

    // Control and lookup state registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            table_valid_q <= 1'b0;
            load_done_q   <= 1'b0;
            lkp_data_q    <= '0;
            lkp_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            table_valid_q <= table_valid_d;
            load_done_q   <= load_done_d;
            lkp_data_q    <= lkp_data_d;
            lkp_valid_q   <= lkp_valid_d;
        end
    end

`ifdef LUT_CHECKSUM_EN
    // Running XOR of data beats and sticky checksum error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
            err_q  <= 1'b0;
        end else begin
            csum_q <= csum_d;
            err_q  <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Table RAM write port: one full row per accepted data beat.
    always_ff @(posedge clk) begin
        // NOTE: the RAM is deliberately not reset; table_valid gates every read until a full load.
        if (wr_en) begin
            mem[cnt_q] <= s_data;
        end
    end

    assign s_ready     = (state_q == LOAD) || (state_q == CHECK);
    assign load_done   = load_done_q;
    assign table_valid = table_valid_q;
    assign lkp_data    = lkp_data_q;
    assign lkp_valid   = lkp_valid_q;

endmodule

// File: tb/tb_lut_table_loader.sv
// Self-checking bench for lut_table_loader with a lookup scoreboard.
// Build with +define+LUT_CHECKSUM_EN to exercise the checksum variant.
module tb_lut_table_loader;

    localparam int IN_BITS      = 6;
    localparam int OUT_BITS     = 2;
    localparam int BEAT_ENTRIES = 4;
    localparam int BEAT_W       = BEAT_ENTRIES * OUT_BITS;
    localparam int NUM_BEATS    = (2 ** IN_BITS) / BEAT_ENTRIES;
    localparam int DEPTH        = 2 ** IN_BITS;
`ifdef LUT_CHECKSUM_EN
    localparam int EXTRA_BEATS  = 1;
`else
    localparam int EXTRA_BEATS  = 0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                load_start;
    logic [BEAT_W-1:0]   s_data;
    logic                s_valid;
    logic                s_ready;
    logic                load_done;
    logic                table_valid;
    logic                lkp_en;
    logic [IN_BITS-1:0]  lkp_addr;
    logic [OUT_BITS-1:0] lkp_data;
    logic                lkp_valid;
    logic                err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int acc_cnt = 0;

    logic [OUT_BITS-1:0] model_mem [DEPTH];
    logic                model_tv;
    logic [OUT_BITS:0]   exp_q[$];
    string               tag_q[$];

    lut_table_loader #(
        .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .BEAT_ENTRIES(BEAT_ENTRIES)
    ) dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .load_done(load_done), .table_valid(table_valid),
        .lkp_en(lkp_en), .lkp_addr(lkp_addr),
        .lkp_data(lkp_data), .lkp_valid(lkp_valid), .err(err)
    );

    always #5 clk = ~clk;

    // Count committed loads and accepted beats as seen at each rising edge.
    always @(posedge clk) begin
        if (load_done) done_cnt++;
        if (s_valid && s_ready) acc_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Fill the reference table from a repeated beat pattern.
    task automatic model_fill(input logic [BEAT_W-1:0] beat);
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = beat[(i % BEAT_ENTRIES)*OUT_BITS +: OUT_BITS];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load_start();
        load_start = 1'b1;
        model_tv   = 1'b0;
        tick();
        load_start = 1'b0;
    endtask

    // Present one beat and hold it until the edge that accepts it.
    task automatic send_beat(input logic [BEAT_W-1:0] d, input bit gap);
        int t;
        if (gap) begin
            s_valid = 1'b0;
            tick();
        end
        s_valid = 1'b1;
        s_data  = d;
        t = 0;
        while (!s_ready && t < 20) begin
            tick();
            t++;
        end
        if (!s_ready) check("beat_ready_timeout", 32'(s_ready), 32'd1);
        tick();
    endtask

    // Full table load of a repeated beat, optional gaps, optional checksum beat.
    task automatic full_load(input logic [BEAT_W-1:0] beat, input bit gaps,
                             input logic [BEAT_W-1:0] csum, input string tag);
        int d0, a0;
        d0 = done_cnt;
        a0 = acc_cnt;
        pulse_load_start();
        for (int i = 0; i < NUM_BEATS; i++) send_beat(beat, gaps);
`ifdef LUT_CHECKSUM_EN
        send_beat(csum, gaps);
`else
        if (csum != '0) $display("note: checksum beat ignored in this build");
`endif
        s_valid = 1'b0;
        repeat (3) tick();
        check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_accepts"}, 32'(acc_cnt - a0), 32'(NUM_BEATS + EXTRA_BEATS));
        check({tag, "_tv"}, 32'(table_valid), 32'd1);
        model_fill(beat);
        model_tv = 1'b1;
    endtask

    task automatic pop_check();
        logic [OUT_BITS:0] e;
        string t;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check({t, "_valid"}, 32'(lkp_valid), 32'(e[OUT_BITS]));
            check({t, "_data"}, 32'(lkp_data), 32'(e[OUT_BITS-1:0]));
        end
    endtask

    // One lookup cycle: expectation pushed at drive time, compared one cycle later.
    task automatic lookup(input logic [IN_BITS-1:0] a, input bit en, input string tag);
        lkp_en   = en;
        lkp_addr = a;
        exp_q.push_back({en & model_tv, (en & model_tv) ? model_mem[a] : {OUT_BITS{1'b0}}});
        tag_q.push_back(tag);
        tick();
        lkp_en = 1'b0;
        pop_check();
    endtask

    initial begin
        int d0;
        rst = 1'b1; load_start = 1'b0; s_data = '0; s_valid = 1'b0;
        lkp_en = 1'b0; lkp_addr = '0; model_tv = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        repeat (2) tick();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_tv", 32'(table_valid), 32'd0);
        check("rst_lkp_valid", 32'(lkp_valid), 32'd0);
        check("rst_lkp_data", 32'(lkp_data), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();

        // Lookups before any load stay invalid and zero.
        for (int i = 0; i < 3; i++) lookup(6'd5, 1'b1, "preload");

        // Back-to-back load of E4; checksum of 16 identical beats is 0.
        full_load(8'hE4, 1'b0, 8'h00, "load_e4");
        lookup(6'd0,  1'b1, "e4_a0");
        lookup(6'd6,  1'b1, "e4_a6");
        lookup(6'd12, 1'b1, "e4_a12");
        lookup(6'd63, 1'b1, "e4_a63");
        lookup(6'd63, 1'b0, "e4_en_low");
        check("e4_a6_ref", 32'(model_mem[6]), 32'h2);

        // Same load with gaps on alternating cycles.
        full_load(8'hE4, 1'b1, 8'h00, "load_gap");
        lookup(6'd6,  1'b1, "gap_a6");
        lookup(6'd63, 1'b1, "gap_a63");

        // Restart after 7 beats; beat presented with load_start is discarded.
        d0 = done_cnt;
        pulse_load_start();
        for (int i = 0; i < 7; i++) send_beat(8'hE4, 1'b0);
        lookup(6'd0, 1'b1, "reload_lkp");
        s_valid = 1'b1; s_data = 8'hE4;
        pulse_load_start();
        for (int i = 0; i < NUM_BEATS; i++) send_beat(8'h1B, 1'b0);
`ifdef LUT_CHECKSUM_EN
        send_beat(8'h00, 1'b0);
`endif
        s_valid = 1'b0;
        repeat (3) tick();
        check("restart_done_once", 32'(done_cnt - d0), 32'd1);
        check("restart_tv", 32'(table_valid), 32'd1);
        model_fill(8'h1B);
        model_tv = 1'b1;
        lookup(6'd3, 1'b1, "rs_a3");
        lookup(6'd0, 1'b1, "rs_a0");
        lookup(6'd4, 1'b1, "rs_a4");

        // Asynchronous reset in the middle of a load.
        pulse_load_start();
        for (int i = 0; i < 10; i++) send_beat(8'hE4, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_tv", 32'(table_valid), 32'd0);
        check("midrst_s_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        lookup(6'd5, 1'b1, "midrst_lkp");

`ifdef LUT_CHECKSUM_EN
        // Bad checksum: sticky err, no commit, cleared by the next load_start.
        d0 = done_cnt;
        pulse_load_start();
        for (int i = 0; i < NUM_BEATS; i++) send_beat(8'hE4, 1'b0);
        send_beat(8'h01, 1'b0);
        s_valid = 1'b0;
        repeat (3) tick();
        check("csum_err", 32'(err), 32'd1);
        check("csum_tv", 32'(table_valid), 32'd0);
        check("csum_no_done", 32'(done_cnt - d0), 32'd0);
        check("csum_s_ready", 32'(s_ready), 32'd0);
        lookup(6'd0, 1'b1, "csum_lkp");
        pulse_load_start();
        check("csum_err_clr", 32'(err), 32'd0);
        check("csum_reloading", 32'(s_ready), 32'd1);
`endif

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
